// File: rtl/alu_seq.sv
// Sequential execute-stage ALU: single-cycle data-processing ops, WIDTH-cycle shift-add MUL,
// NZCV status register written only by completing ops that carry the S bit.
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       exe_command,
    input  logic             s_bit,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_res,
    output logic [3:0]       status_bits
);

    localparam int unsigned   CW      = $clog2(WIDTH);
    localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

    localparam logic [3:0] OpMov = 4'b0001;
    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpAdc = 4'b0011;
    localparam logic [3:0] OpSub = 4'b0100;
    localparam logic [3:0] OpSbc = 4'b0101;
    localparam logic [3:0] OpAnd = 4'b0110;
    localparam logic [3:0] OpOrr = 4'b0111;
    localparam logic [3:0] OpEor = 4'b1000;
    localparam logic [3:0] OpMvn = 4'b1001;
    localparam logic [3:0] OpMul = 4'b1010;

    typedef enum logic [1:0] {StIdle, StExec, StMul} state_e;

    state_e           r_state;
    logic [3:0]       r_op;
    logic             r_s;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_alu_res;
    logic [3:0]       r_status;

    logic             w_accept;
    logic             w_done;
    logic             w_is_sub;
    logic             w_is_arith;
    logic             w_known;
    logic             w_cin;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_mul_res;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic [3:0]       w_flags;

    assign w_accept = in_valid && r_in_ready;
    assign w_done   = (r_state == StExec) || ((r_state == StMul) && (r_cnt == CntLast));

    // Carry-in is read in the execute cycle, so an op accepted on the edge that retires a
    // flag-setting op already sees that op's C without a bubble.
    always_comb begin
        w_mul_res  = r_acc + (r_b[0] ? r_a : '0);
        w_is_sub   = (r_op == OpSub) || (r_op == OpSbc);
        w_is_arith = (r_op == OpAdd) || (r_op == OpAdc) || w_is_sub;
        w_b_eff    = w_is_sub ? ~r_b : r_b;
        w_cin      = 1'b0;
        unique case (r_op)
            OpAdc, OpSbc: w_cin = r_status[1];
            OpSub:        w_cin = 1'b1;
            default:      w_cin = 1'b0;
        endcase
        w_sum = {1'b0, r_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};

        w_res   = '0;
        w_known = 1'b1;
        unique case (r_op)
            OpMov:                      w_res = r_b;
            OpMvn:                      w_res = ~r_b;
            OpAdd, OpAdc, OpSub, OpSbc: w_res = w_sum[WIDTH-1:0];
            OpAnd:                      w_res = r_a & r_b;
            OpOrr:                      w_res = r_a | r_b;
            OpEor:                      w_res = r_a ^ r_b;
            OpMul:                      w_res = w_mul_res;
            default: begin
                w_res   = '0;
                w_known = 1'b0;
            end
        endcase

        w_c = w_is_arith ? w_sum[WIDTH] : r_status[1];
        w_v = w_is_arith ? ((r_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                            (w_sum[WIDTH-1] != r_a[WIDTH-1])) : r_status[0];
        w_flags = {w_res[WIDTH-1], (w_res == '0), w_c, w_v};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_op        <= 4'b0000;
            r_s         <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_alu_res   <= '0;
            r_status    <= 4'b0000;
        end else begin
            r_out_valid <= 1'b0;
            if (w_done) begin
                r_alu_res   <= w_res;
                r_out_valid <= 1'b1;
                r_in_ready  <= 1'b1;
                r_state     <= StIdle;
                if (r_s && w_known) begin
                    r_status <= w_flags;
                end
            end else if (r_state == StMul) begin
                r_acc <= w_mul_res;
                r_a   <= r_a << 1;
                r_b   <= r_b >> 1;
                r_cnt <= r_cnt + 1'b1;
            end

            // A completion cycle is also an accept cycle; the new op overrides the next state.
            if (w_accept) begin
                r_op  <= exe_command;
                r_s   <= s_bit;
                r_a   <= val1;
                r_b   <= val2;
                r_acc <= '0;
                r_cnt <= '0;
                if (exe_command == OpMul) begin
                    r_state    <= StMul;
                    r_in_ready <= 1'b0;
                end else begin
                    r_state <= StExec;
                end
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign alu_res     = r_alu_res;
    assign status_bits = r_status;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus randomized op streams checked
// against a sequential arithmetic reference model, on WIDTH=32 and WIDTH=8 instances.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, in_ready, s_bit, out_valid;
    logic [3:0]  exe_command, status_bits;
    logic [31:0] val1, val2, alu_res;

    logic        in_valid_8, in_ready_8, s_bit_8, out_valid_8;
    logic [3:0]  exe_command_8, status_bits_8;
    logic [7:0]  val1_8, val2_8, alu_res_8;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .exe_command(exe_command), .s_bit(s_bit), .val1(val1), .val2(val2),
        .out_valid(out_valid), .alu_res(alu_res), .status_bits(status_bits)
    );

    alu_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid_8), .in_ready(in_ready_8),
        .exe_command(exe_command_8), .s_bit(s_bit_8), .val1(val1_8), .val2(val2_8),
        .out_valid(out_valid_8), .alu_res(alu_res_8), .status_bits(status_bits_8)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Sequential reference: each op sees the flags left by every earlier op. Returns {nzcv, res}.
    function automatic logic [35:0] ref_op(input int w, input logic [3:0] op,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic s, input logic [3:0] st);
        longint mask, lim, ua, ub, sa, sb, ures, sres, cin, bor;
        logic c, v, known, arith;
        logic [31:0] res;
        logic [3:0]  nst;
        mask = (longint'(1) << w) - 1;
        lim  = longint'(1) << (w - 1);
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        sa   = (ua >= lim) ? ua - (mask + 1) : ua;
        sb   = (ub >= lim) ? ub - (mask + 1) : ub;
        cin  = st[1] ? 1 : 0;
        bor  = 1 - cin;
        c = st[1]; v = st[0]; known = 1'b1; arith = 1'b0; sres = 0; ures = 0;
        case (op)
            4'b0001: ures = ub;
            4'b1001: ures = ~ub;
            4'b0010: begin ures = ua + ub;       sres = sa + sb;       c = ures > mask; arith = 1; end
            4'b0011: begin ures = ua + ub + cin; sres = sa + sb + cin; c = ures > mask; arith = 1; end
            4'b0100: begin ures = ua - ub;       sres = sa - sb;       c = ua >= ub;    arith = 1; end
            4'b0101: begin ures = ua - ub - bor; sres = sa - sb - bor; c = ua >= ub + bor; arith = 1; end
            4'b0110: ures = ua & ub;
            4'b0111: ures = ua | ub;
            4'b1000: ures = ua ^ ub;
            4'b1010: ures = ua * ub;
            default: begin ures = 0; known = 1'b0; end
        endcase
        if (arith) v = (sres >= lim) || (sres < -lim);
        res = 32'(ures & mask);
        nst = st;
        if (s && known) nst = {res[w-1], (res == 32'd0), c, v};
        return {nst, res};
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(7, 0))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_valid_8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Issue one op on the 32-bit instance, scramble inputs after accept, wait for out_valid.
    task automatic drive_op32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic s, output int lat);
        @(negedge clk);
        exe_command = op; val1 = a; val2 = b; s_bit = s; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; exe_command = 4'($urandom); val1 = $urandom; val2 = $urandom;
        s_bit = ~s;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 100);
    endtask

    task automatic drive_op8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                             input logic s, output int lat);
        @(negedge clk);
        exe_command_8 = op; val1_8 = a; val2_8 = b; s_bit_8 = s; in_valid_8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_8 = 1'b0; val1_8 = 8'($urandom); val2_8 = 8'($urandom);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid_8 && lat < 100);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; exe_command = '0; s_bit = 1'b0; val1 = '0; val2 = '0;
        in_valid_8 = 1'b0; exe_command_8 = '0; s_bit_8 = 1'b0; val1_8 = '0; val2_8 = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({alu_res, status_bits, out_valid, in_ready} !== {32'd0, 4'b0000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset32: res=%h nzcv=%b ov=%b rdy=%b, need 0/0000/0/1",
                     alu_res, status_bits, out_valid, in_ready);
        end
        checks++;
        if ({alu_res_8, status_bits_8, out_valid_8, in_ready_8} !== {8'd0, 4'b0000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset8: res=%h nzcv=%b ov=%b rdy=%b, need 0/0000/0/1",
                     alu_res_8, status_bits_8, out_valid_8, in_ready_8);
        end
        rst = 1'b0;
    endtask

    task automatic test_add_overflow();
        int lat;
        drive_op32(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, lat);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL add_latency: got %0d need 1", lat); end
        checks++;
        if (alu_res !== 32'h8000_0000) begin
            errors++; $display("FAIL add_result: got %h need 80000000", alu_res);
        end
        checks++;
        if (status_bits !== 4'b1001) begin
            errors++; $display("FAIL add_flags: got %b need 1001", status_bits);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL add_pulse_width: out_valid=%b need 0", out_valid);
        end
    endtask

    task automatic test_sub_sbc_back_to_back();
        @(negedge clk);
        exe_command = 4'b0100; val1 = 32'd5; val2 = 32'd5; s_bit = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_ready: got %b need 1", in_ready);
        end
        exe_command = 4'b0101; val1 = 32'd0; val2 = 32'd0; s_bit = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({out_valid, alu_res, status_bits} !== {1'b1, 32'd0, 4'b0110}) begin
            errors++;
            $display("FAIL sub_result: ov=%b res=%h nzcv=%b need 1/00000000/0110",
                     out_valid, alu_res, status_bits);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, alu_res, status_bits} !== {1'b1, 32'd0, 4'b0110}) begin
            errors++;
            $display("FAIL sbc_result: ov=%b res=%h nzcv=%b need 1/00000000/0110",
                     out_valid, alu_res, status_bits);
        end
    endtask

    task automatic test_mul();
        int lat = 0;
        int bad = 0;
        @(negedge clk);
        exe_command = 4'b1010; val1 = 32'hFFFF_FFFF; val2 = 32'd3; s_bit = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        do begin
            // Junk requests while busy must be ignored.
            in_valid = 1'($urandom); exe_command = 4'($urandom); val1 = $urandom; val2 = $urandom;
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat < 32 && (in_ready !== 1'b0 || out_valid !== 1'b0)) bad++;
        end while (!out_valid && lat < 100);
        in_valid = 1'b0;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL mul_busy: %0d bad cycles need 0", bad); end
        checks++;
        if (lat !== 32) begin errors++; $display("FAIL mul_latency: got %0d need 32", lat); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL mul_done_ready: got %b need 1", in_ready); end
        checks++;
        if (alu_res !== 32'hFFFF_FFFD) begin
            errors++; $display("FAIL mul_result: got %h need fffffffd", alu_res);
        end
        checks++;
        if (status_bits !== 4'b1010) begin
            errors++; $display("FAIL mul_flags: got %b need 1010", status_bits);
        end
    endtask

    task automatic test_logic_s0_and_reserved();
        int lat;
        drive_op32(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, lat);
        drive_op32(4'b0110, 32'h0000_00F0, 32'h0000_000F, 1'b0, lat);
        checks++;
        if ({lat, alu_res, status_bits} !== {32'd1, 32'd0, 4'b1001}) begin
            errors++;
            $display("FAIL and_s0: lat=%0d res=%h nzcv=%b need 1/00000000/1001",
                     lat, alu_res, status_bits);
        end
        drive_op32(4'b1111, 32'd5, 32'd3, 1'b1, lat);
        checks++;
        if ({lat, alu_res, status_bits} !== {32'd1, 32'd0, 4'b1001}) begin
            errors++;
            $display("FAIL reserved: lat=%0d res=%h nzcv=%b need 1/00000000/1001",
                     lat, alu_res, status_bits);
        end
    endtask

    task automatic test_reset_mid_mul();
        int lat = 0;
        int seen = 0;
        @(negedge clk);
        exe_command = 4'b1010; val1 = 32'd7; val2 = 32'd9; s_bit = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({alu_res, status_bits, out_valid, in_ready} !== {32'd0, 4'b0000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL mul_abort: res=%h nzcv=%b ov=%b rdy=%b need 0/0000/0/1",
                     alu_res, status_bits, out_valid, in_ready);
        end
        repeat (2) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        rst = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL mul_abort_no_valid: got %0d need 0", seen); end
        drive_op32(4'b0010, 32'd2, 32'd3, 1'b1, lat);
        checks++;
        if ({lat, alu_res, status_bits} !== {32'd1, 32'd5, 4'b0000}) begin
            errors++;
            $display("FAIL add_after_abort: lat=%0d res=%h nzcv=%b need 1/00000005/0000",
                     lat, alu_res, status_bits);
        end
    endtask

    // Randomized stream with gaps, junk while busy, back-to-back issue and MULs mixed in.
    task automatic test_random_stream(input int n_ops);
        logic [35:0] exp_q[$];
        logic [35:0] e;
        logic [3:0]  m_st = 4'b0000;
        logic [3:0]  op;
        logic [31:0] a, b;
        logic        s;
        int issued = 0;
        int got = 0;
        int cycles = 0;
        apply_reset();
        while (got < n_ops && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_spurious_valid: res=%h with nothing pending", alu_res);
                end else begin
                    e = exp_q.pop_front();
                    if ({alu_res, status_bits} !== {e[31:0], e[35:32]}) begin
                        errors++;
                        $display("FAIL rand_op%0d: res=%h nzcv=%b need %h/%b",
                                 got, alu_res, status_bits, e[31:0], e[35:32]);
                    end
                end
                got++;
            end
            if (in_ready && issued < n_ops && $urandom_range(3, 0) != 0) begin
                op = 4'($urandom_range(15, 0)); a = pick32(); b = pick32(); s = 1'($urandom);
                e = ref_op(32, op, a, b, s, m_st);
                m_st = e[35:32];
                exp_q.push_back(e);
                exe_command = op; val1 = a; val2 = b; s_bit = s; in_valid = 1'b1;
                issued++;
            end else begin
                in_valid = in_ready ? 1'b0 : 1'($urandom);
                exe_command = 4'($urandom); val1 = $urandom; val2 = $urandom; s_bit = 1'($urandom);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (got !== n_ops) begin
            errors++; $display("FAIL rand_timeout: completed %0d need %0d", got, n_ops);
        end
    endtask

    task automatic test_width8();
        int lat;
        logic [35:0] e;
        logic [3:0]  m_st;
        logic [3:0]  op;
        logic [7:0]  a, b;
        logic        s;
        int bad = 0;
        apply_reset();
        drive_op8(4'b0010, 8'hFF, 8'h01, 1'b1, lat);
        checks++;
        if ({lat, alu_res_8, status_bits_8} !== {32'd1, 8'h00, 4'b0110}) begin
            errors++;
            $display("FAIL w8_add: lat=%0d res=%h nzcv=%b need 1/00/0110", lat, alu_res_8, status_bits_8);
        end
        drive_op8(4'b1010, 8'h10, 8'h10, 1'b1, lat);
        checks++;
        if ({lat, alu_res_8, status_bits_8} !== {32'd8, 8'h00, 4'b0110}) begin
            errors++;
            $display("FAIL w8_mul: lat=%0d res=%h nzcv=%b need 8/00/0110", lat, alu_res_8, status_bits_8);
        end
        m_st = 4'b0110;
        for (int i = 0; i < 24; i++) begin
            op = 4'($urandom_range(15, 0)); a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
            e = ref_op(8, op, {24'd0, a}, {24'd0, b}, s, m_st);
            m_st = e[35:32];
            drive_op8(op, a, b, s, lat);
            if (lat !== ((op == 4'b1010) ? 8 : 1) || alu_res_8 !== e[7:0] ||
                status_bits_8 !== e[35:32]) begin
                bad++;
                $display("FAIL w8_rand%0d op=%b: lat=%0d res=%h nzcv=%b need res=%h nzcv=%b",
                         i, op, lat, alu_res_8, status_bits_8, e[7:0], e[35:32]);
            end
        end
        checks++;
        if (bad !== 0) errors++;
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_sbc_back_to_back();
        test_mul();
        test_logic_s0_and_reserved();
        test_reset_mid_mul();
        test_random_stream(80);
        test_width8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential, parametrised-width execute-stage ALU; successor to the single-cycle combinational ALU. Accepts one operation per handshake, computes the ARM-style data-processing ops in one cycle, and computes a new MUL in WIDTH cycles. Owns the NZCV status register, which updates only on the S bit. Sits between the ID/EX pipeline register and the EX/MEM register, and stalls the front end through `in_ready`.

## Interface
- `WIDTH`, default 32: operand and result width; must be ≥ 4.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operation present on `exe_command`, `val1`, `val2`, `s_bit`.
- `in_ready`  out  1  block can accept an operation this cycle.
- `exe_command`  in  4  opcode.
- `s_bit`  in  1  update the status register with this op's flags.
- `val1`, `val2`  in  WIDTH  operands, two's complement.
- `out_valid`  out  1  one-cycle pulse: `alu_res` and `status_bits` are valid.
- `alu_res`  out  WIDTH  registered result.
- `status_bits`  out  4  registered {N, Z, C, V}.

## Operation
- Opcodes:
  - 0001 MOV: val2.
  - 1001 MVN: ~val2.
  - 0010 ADD: val1 + val2.
  - 0011 ADC: val1 + val2 + C.
  - 0100 SUB: val1 − val2.
  - 0101 SBC: val1 − val2 − !C.
  - 0110 AND, 0111 ORR, 1000 EOR.
  - 1010 MUL: low WIDTH bits of val1 × val2.
  - All other codes are reserved: result 0, no flag update, still complete in 1 cycle.
- Arithmetic is computed at WIDTH+1 bits.
  - ADD/ADC: C = bit WIDTH of the sum.
  - SUB/SBC are computed as val1 + ~val2 + cin, with cin = 1 for SUB and cin = C for SBC. C = carry out, i.e. NOT borrow.
  - V = signed overflow: operand sign bits equal (after inversion for SUB/SBC) and the result sign differs.
- Logic ops, MOV, MVN, MUL: N and Z come from the result; C and V keep their previous values.
- N = result[WIDTH−1]; Z = (result == 0).
- The status register updates only at completion of an op with `s_bit` = 1 and a non-reserved opcode. `s_bit` is captured at accept.
- ADC and SBC read C as held in the status register at accept time.
- `status_bits` always shows the status register. When an op completes without updating it, `status_bits` shows the old value during `out_valid`.
- FSM states:
  - IDLE: `in_ready` = 1. Accepting a non-MUL op → EXEC. Accepting MUL → MUL.
  - EXEC: one cycle. Registers the result, pulses `out_valid`, `in_ready` = 1. Accept → EXEC or MUL; no accept → IDLE.
  - MUL: `in_ready` = 0. Shift-add: multiplier shifts right, multiplicand shifts left, a 0..WIDTH−1 counter tracks iterations. After WIDTH iterations → EXEC-equivalent completion cycle with `out_valid` = 1 and `in_ready` = 1.
- Operands are captured at accept; input changes after accept have no effect.

## Timing
- Reset, asynchronous, state forced to IDLE:
  - `alu_res` = 0, `status_bits` = 4'b0000, `out_valid` = 0, `in_ready` = 1.
  - Multiply counter and internal registers = 0.
- Non-MUL latency: accept at edge k; `out_valid` = 1 after edge k+1.
- Throughput for non-MUL ops: one op per cycle, back-to-back.
- MUL latency: accept at edge k; `out_valid` = 1 after edge k+WIDTH. `in_ready` = 0 after edges k+1 … k+WIDTH−1.
- Flag dependency: an op accepted during another op's `out_valid` cycle sees the flags that op wrote, with no bubble. The status register updates on the same edge that raises `out_valid`, and accept samples it afterwards.
- `in_valid` while `in_ready` = 0 is ignored; the upstream stage must hold its operands.
- `rst` asserted during MUL aborts the operation. No `out_valid` is produced and flags are not written.
- MUL with val1 or val2 = 0 still takes WIDTH cycles; there is no early termination.
- Wrap-around: results are truncated to WIDTH bits, so the MUL high half is discarded.

## Test plan
- Reset, then ADD, WIDTH=32, s=1: 0x7FFFFFFF + 1 → after 1 cycle `alu_res` = 0x80000000, NZCV = 1001.
- SUB 5 − 5 with s=1, then back-to-back SBC 0 − 0 → first op NZCV = 0110 (C = no borrow). SBC uses C = 1 → result 0, NZCV = 0110.
- MUL, WIDTH=32: 0xFFFFFFFF × 3 with s=1 → `out_valid` exactly 32 cycles after accept, `alu_res` = 0xFFFFFFFD. N = 1, Z = 0, C and V unchanged. `in_ready` = 0 for 31 cycles.
- AND 0xF0 & 0x0F with s=0 after a flag-setting op → `alu_res` = 0, `status_bits` unchanged. Reserved opcode 1111 → `alu_res` = 0, flags unchanged.
- Assert `rst` at cycle 10 of a MUL → all outputs return to reset values immediately, no `out_valid`. A following ADD 2+3 yields 5 one cycle after accept.
- WIDTH=8 instance: ADD 0xFF + 0x01 → 0x00, NZCV = 0110. MUL 0x10 × 0x10 → 0x00 after 8 cycles.
